serial_adder: RTL
=================

# serial_adder

Bit-serial N-bit adder built around a single full-adder cell and a registered carry. It accepts two WIDTH-bit operands plus carry-in on a start strobe, and adds one bit per clock, LSB first. It presents the registered sum and carry-out with a one-cycle done pulse. It is the area-minimal sequential counterpart of the ripple-carry adder and shares its 1-bit full-adder cell; downstream datapaths use it where latency is cheaper than WIDTH cascaded cells.

## Interface
Parameters:
- WIDTH, default 8: operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  request strobe; sampled only when busy=0.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- cin  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse: sum/cout updated this cycle.
- sum  output  WIDTH  registered result a+b+cin mod 2^WIDTH.
- cout  output  1  registered carry-out, bit WIDTH of a+b+cin.

## Operation
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, carry and bit counter cleared. Reset overrides every other input, including mid-operation; the aborted result is discarded and done is not pulsed.
- FSM states:
  - IDLE: busy=0. On start=1, latch a and b into shift registers A_sh and B_sh, latch cin into carry, clear counter, and go to RUN.
  - RUN: busy=1. Each edge evaluates the full-adder cell on A_sh[0], B_sh[0] and carry. The sum bit is shifted into the MSB of S_sh (S_sh shifts right), carry takes the cell carry-out, A_sh and B_sh shift right, and counter increments. On the edge where counter==WIDTH-1: sum<=final S_sh value, cout<=final carry, go to DONE.
  - DONE: busy=0, done=1 for exactly this cycle, then go to IDLE. A start in DONE is accepted identically to IDLE, giving back-to-back operation without an idle cycle.
- start while busy=1 is ignored: no queuing and no operand resample.
- sum and cout change only on the completion edge. They hold their value through the next entire operation until its completion edge.
- Arithmetic: unsigned, so {cout,sum} == a+b+cin exactly. Counter width is clog2(WIDTH), and counter never wraps past WIDTH-1.
- a, b and cin may change freely after the accepting edge.

## Timing
- The accepting edge is edge E0, the first rising edge with start=1 and busy=0.
- busy is high from after E0 through E0+WIDTH.
- The completion edge is E0+WIDTH. sum, cout and done update there, and done drops after E0+WIDTH+1.
- Latency from start to done is WIDTH cycles. Throughput is one result per WIDTH+1 cycles with continuous start held high.
- No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset values: hold rst for 2 cycles. Required: busy=0, done=0, sum=0x00, cout=0. Repeat with start=1 held during reset: busy must still stay 0.
- Directed adds, WIDTH=8, pulse start for one cycle:
  - a=0x3C, b=0x42, cin=0 → done exactly 8 cycles after the accepting edge, sum=0x7E, cout=0.
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
  - a=0xA5, b=0x5A, cin=1 → sum=0x00, cout=1.
- Ignored start and operand hold:
  - Start 0x10+0x20, then pulse start with 0xFF+0xFF while busy=1 → single done with sum=0x30, cout=0.
  - Change a and b after acceptance → result unaffected.
  - Previous sum holds during RUN.
- Reset mid-operation: start 0x0F+0x01, assert rst at cycle 4 of RUN → IDLE next edge, busy=0, sum=0, no done pulse. A fresh start 0x01+0x01 afterwards → sum=0x02.
- Back-to-back: hold start=1 with a=0x01, b=0x01, cin=0, then switch the operands to 0x80+0x80 during the DONE cycle. Required: second accept on the DONE edge, done pulses 9 cycles apart, second result sum=0x00, cout=1.
- Exhaustive, WIDTH=4: all 512 combinations of a, b and cin, each compared against a golden a+b+cin model with done-latency fixed at 4 cycles.

Source files
------------

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Brief    : Bit-serial WIDTH-bit adder, one full-adder cell plus a registered
//            carry, LSB first, registered sum/cout with a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================

module serial_adder_fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int            c_cw   = $clog2(WIDTH);
    localparam logic [c_cw-1:0] c_last = c_cw'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_s_sh;
    logic             r_carry;
    logic [c_cw-1:0]  r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_s_next;

    serial_adder_fa u_fa (
        .i_a (r_a_sh[0]),
        .i_b (r_b_sh[0]),
        .i_c (r_carry),
        .o_s (w_s),
        .o_c (w_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at bit 0.
    assign w_s_next = {w_s, r_s_sh[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_s_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a_sh  <= a;
                        r_b_sh  <= b;
                        r_s_sh  <= '0;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_s_sh  <= w_s_next;
                    r_carry <= w_co;
                    if (r_cnt == c_last) begin
                        r_sum   <= w_s_next;
                        r_cout  <= w_co;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

`default_nettype wire
